// File: rtl/ins_fmt_pkg.sv
// ---------------------------------------------------------------------------
// ins_fmt_pkg
//   Instruction format definitions shared by the instruction encoder and the
//   ImmGen decoder, so both sides agree on which opcodes carry which
//   immediate layout.
//   Contents:
//     OP_*       opcode constants grouped by immediate format
//     fmt_e      immediate format enum (R, ISGN, IUNS, SH, U, S, J)
//     opFormat() opcode -> format lookup, R for every unlisted opcode
// ---------------------------------------------------------------------------
package ins_fmt_pkg;

    // Sign-extended 12-bit immediate in Ins[31:20]
    localparam logic [4:0] OP_ISGN_0 = 5'b00010;
    localparam logic [4:0] OP_ISGN_1 = 5'b01111;
    localparam logic [4:0] OP_ISGN_2 = 5'b10100;

    // Zero-extended 12-bit immediate in Ins[31:20]
    localparam logic [4:0] OP_IUNS_0 = 5'b00101;
    localparam logic [4:0] OP_IUNS_1 = 5'b00111;
    localparam logic [4:0] OP_IUNS_2 = 5'b01001;

    // 6-bit shift amount in Ins[25:20]
    localparam logic [4:0] OP_SH_0   = 5'b01011;
    localparam logic [4:0] OP_SH_1   = 5'b01101;

    // Upper 20 bits in Ins[31:12]
    localparam logic [4:0] OP_U      = 5'b01110;

    // Store-style split immediate
    localparam logic [4:0] OP_S_0    = 5'b10000;
    localparam logic [4:0] OP_S_1    = 5'b10001;
    localparam logic [4:0] OP_S_2    = 5'b10010;

    // Jump: Imm[19:0] placed unshifted in Ins[31:12]
    localparam logic [4:0] OP_J      = 5'b10011;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_ISGN,
        FMT_IUNS,
        FMT_SH,
        FMT_U,
        FMT_S,
        FMT_J
    } fmt_e;

    function automatic fmt_e opFormat(input logic [4:0] op);
        fmt_e f;
        f = FMT_R;
        case (op)
            OP_ISGN_0, OP_ISGN_1, OP_ISGN_2: f = FMT_ISGN;
            OP_IUNS_0, OP_IUNS_1, OP_IUNS_2: f = FMT_IUNS;
            OP_SH_0, OP_SH_1:                f = FMT_SH;
            OP_U:                            f = FMT_U;
            OP_S_0, OP_S_1, OP_S_2:          f = FMT_S;
            OP_J:                            f = FMT_J;
            default:                         f = FMT_R;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_range_chk.sv
// ---------------------------------------------------------------------------
// imm_range_chk
//   Combinational check that a 32-bit immediate is representable in the
//   immediate field of the given instruction format.
//   Ports:
//     i_fmt  in   fmt_e   format of the instruction being encoded
//     i_imm  in   32      immediate value
//     o_ok   out  1       1 when the immediate fits without truncation
// ---------------------------------------------------------------------------
module imm_range_chk
    import ins_fmt_pkg::*;
(
    input  fmt_e        i_fmt,
    input  logic [31:0] i_imm,
    output logic        o_ok
);

    // Signed ranges are checked by requiring every bit above the field's
    // sign bit to equal that sign bit; unsigned ranges need zero upper bits.
    always_comb begin
        o_ok = 1'b1;
        case (i_fmt)
            FMT_ISGN, FMT_S: o_ok = (i_imm[31:11] == {21{i_imm[11]}});
            FMT_IUNS:        o_ok = (i_imm[31:12] == 20'd0);
            FMT_SH:          o_ok = (i_imm[31:6]  == 26'd0);
            FMT_U:           o_ok = (i_imm[11:0]  == 12'd0);
            FMT_J:           o_ok = (i_imm[31:19] == {13{i_imm[19]}});
            default:         o_ok = 1'b1;
        endcase
    end

endmodule

// File: rtl/ins_encoder.sv
// ---------------------------------------------------------------------------
// ins_encoder
//   Packs opcode, register fields and a 32-bit immediate into one 32-bit
//   instruction word using the ImmGen field layout, and tags each emitted
//   word with an incrementing IMem word address. One registered stage with
//   valid/ready handshakes on both sides.
//   Build option:
//     IMM_RANGE_CHECK_EN  when defined, out-of-range immediates raise
//                         RangeErr for that word and bump ErrCnt; when not
//                         defined, RangeErr and ErrCnt are tied to 0.
//   Parameters:
//     ADDR_W    width of the wrapping word address counter
//     ERRCNT_W  width of the saturating range-error counter
//   Ports:
//     clk, rstn                  clock, async active-low reset
//     Flush                      sync clear of held word and address
//     InValid/InReady            input handshake
//     OpIn..Funct7In, Imm32In    instruction fields and immediate
//     InsOut, InsAddrOut         encoded word and its IMem address
//     OutValid/OutReady          output handshake
//     RangeErr, ErrCnt           range error flag and saturating count
// ---------------------------------------------------------------------------
module ins_encoder
    import ins_fmt_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int ERRCNT_W = 8
)
(
    input  logic                clk,
    input  logic                rstn,
    input  logic                Flush,
    input  logic                InValid,
    output logic                InReady,
    input  logic [4:0]          OpIn,
    input  logic [1:0]          Funct2In,
    input  logic [4:0]          RdIn,
    input  logic [2:0]          Funct3In,
    input  logic [4:0]          Rs1In,
    input  logic [4:0]          Rs2In,
    input  logic [6:0]          Funct7In,
    input  logic [31:0]         Imm32In,
    output logic [31:0]         InsOut,
    output logic [ADDR_W-1:0]   InsAddrOut,
    output logic                OutValid,
    input  logic                OutReady,
    output logic                RangeErr,
    output logic [ERRCNT_W-1:0] ErrCnt
);

    fmt_e              w_fmt;
    logic [31:0]       w_encIns;
    logic              w_accept;
    logic              w_outFire;

    logic              r_outValid;
    logic [31:0]       r_ins;
    logic [ADDR_W-1:0] r_addr;

    assign w_fmt     = opFormat(OpIn);
    // Flush blocks the input so nothing is captured in the clearing cycle.
    assign InReady   = !Flush && (!r_outValid || OutReady);
    assign w_accept  = InValid && InReady;
    assign w_outFire = r_outValid && OutReady;

    // Field placement per format; opcode and Funct2 are common to all.
    always_comb begin
        w_encIns = {Funct7In, Rs2In, Rs1In, Funct3In, RdIn, Funct2In, OpIn};
        case (w_fmt)
            FMT_ISGN, FMT_IUNS:
                w_encIns = {Imm32In[11:0], Rs1In, Funct3In, RdIn, Funct2In, OpIn};
            FMT_SH:
                w_encIns = {Funct7In[6:1], Imm32In[5:0], Rs1In, Funct3In, RdIn,
                            Funct2In, OpIn};
            FMT_U:
                w_encIns = {Imm32In[31:12], RdIn, Funct2In, OpIn};
            FMT_J:
                w_encIns = {Imm32In[19:0], RdIn, Funct2In, OpIn};
            FMT_S:
                w_encIns = {Imm32In[11:5], Rs2In, Rs1In, Funct3In, Imm32In[4:0],
                            Funct2In, OpIn};
            default:
                w_encIns = {Funct7In, Rs2In, Rs1In, Funct3In, RdIn, Funct2In, OpIn};
        endcase
    end

    // Output stage: address advances on each consumed word, the held word
    // is replaced on accept and dropped when consumed with nothing behind it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_outValid <= 1'b0;
            r_ins      <= 32'd0;
            r_addr     <= '0;
        end else if (Flush) begin
            r_outValid <= 1'b0;
            r_addr     <= '0;
        end else begin
            if (w_outFire) begin
                r_addr <= r_addr + 1'b1;
            end
            if (w_accept) begin
                r_ins      <= w_encIns;
                r_outValid <= 1'b1;
            end else if (w_outFire) begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign InsOut     = r_ins;
    assign InsAddrOut = r_addr;
    assign OutValid   = r_outValid;

`ifdef IMM_RANGE_CHECK_EN
    logic                w_immOk;
    logic                r_rangeErr;
    logic [ERRCNT_W-1:0] r_errCnt;

    imm_range_chk u_immRangeChk (
        .i_fmt (w_fmt),
        .i_imm (Imm32In),
        .o_ok  (w_immOk)
    );

    // The error flag travels with the captured word; the counter is
    // bumped at input accept and survives Flush.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rangeErr <= 1'b0;
            r_errCnt   <= '0;
        end else if (Flush) begin
            r_rangeErr <= 1'b0;
        end else if (w_accept) begin
            r_rangeErr <= !w_immOk;
            if (!w_immOk && (r_errCnt != '1)) begin
                r_errCnt <= r_errCnt + 1'b1;
            end
        end
    end

    assign RangeErr = r_rangeErr;
    assign ErrCnt   = r_errCnt;
`else
    assign RangeErr = 1'b0;
    assign ErrCnt   = '0;
`endif

endmodule

// File: tb/tb_ins_encoder.sv
// ---------------------------------------------------------------------------
// tb_ins_encoder
//   Self-checking bench for ins_encoder: directed vector table, handshake /
//   address / flush sequences, randomized traffic against a reference model,
//   and an asynchronous reset in the middle of a transfer.
// ---------------------------------------------------------------------------
module tb_ins_encoder;

    localparam int ADDR_W   = 2;
    localparam int ERRCNT_W = 3;
    localparam int CNT_MAX  = (1 << ERRCNT_W) - 1;
`ifdef IMM_RANGE_CHECK_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    localparam int F_R = 0, F_ISGN = 1, F_IUNS = 2, F_SH = 3, F_U = 4, F_S = 5, F_J = 6;

    logic                clk = 1'b0;
    logic                rstn;
    logic                Flush;
    logic                InValid;
    logic                InReady;
    logic [4:0]          OpIn;
    logic [1:0]          Funct2In;
    logic [4:0]          RdIn;
    logic [2:0]          Funct3In;
    logic [4:0]          Rs1In;
    logic [4:0]          Rs2In;
    logic [6:0]          Funct7In;
    logic [31:0]         Imm32In;
    logic [31:0]         InsOut;
    logic [ADDR_W-1:0]   InsAddrOut;
    logic                OutValid;
    logic                OutReady;
    logic                RangeErr;
    logic [ERRCNT_W-1:0] ErrCnt;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the output port should show right now.
    bit          mValid;
    logic [31:0] mIns;
    int          mAddr;
    bit          mErr;
    int          mCnt;

    typedef struct {
        logic [4:0]  op;
        logic [1:0]  f2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] expIns;
        bit          expErr;
    } vec_t;

    vec_t        vecs[14];
    logic [31:0] immPool[16];

    ins_encoder #(.ADDR_W(ADDR_W), .ERRCNT_W(ERRCNT_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .Flush      (Flush),
        .InValid    (InValid),
        .InReady    (InReady),
        .OpIn       (OpIn),
        .Funct2In   (Funct2In),
        .RdIn       (RdIn),
        .Funct3In   (Funct3In),
        .Rs1In      (Rs1In),
        .Rs2In      (Rs2In),
        .Funct7In   (Funct7In),
        .Imm32In    (Imm32In),
        .InsOut     (InsOut),
        .InsAddrOut (InsAddrOut),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .RangeErr   (RangeErr),
        .ErrCnt     (ErrCnt)
    );

    always #5 clk = ~clk;

    function automatic int refFormat(input logic [4:0] op);
        if (op inside {5'b00010, 5'b01111, 5'b10100}) return F_ISGN;
        if (op inside {5'b00101, 5'b00111, 5'b01001}) return F_IUNS;
        if (op inside {5'b01011, 5'b01101})           return F_SH;
        if (op == 5'b01110)                           return F_U;
        if (op inside {5'b10000, 5'b10001, 5'b10010}) return F_S;
        if (op == 5'b10011)                           return F_J;
        return F_R;
    endfunction

    // Word built by shifting each field to its bit position and OR-ing.
    function automatic logic [31:0] refEncode(input logic [4:0] op, input logic [1:0] f2,
                                              input logic [4:0] rd, input logic [2:0] f3,
                                              input logic [4:0] rs1, input logic [4:0] rs2,
                                              input logic [6:0] f7, input logic [31:0] imm);
        logic [31:0] w;
        w = 32'(op) | (32'(f2) << 5);
        case (refFormat(op))
            F_ISGN, F_IUNS: w = w | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                                  | ((imm & 32'hFFF) << 20);
            F_SH:           w = w | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                                  | ((imm & 32'h3F) << 20) | ((32'(f7) >> 1) << 26);
            F_U:            w = w | (32'(rd) << 7) | (imm & 32'hFFFFF000);
            F_J:            w = w | (32'(rd) << 7) | ((imm & 32'hFFFFF) << 12);
            F_S:            w = w | ((imm & 32'h1F) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                                  | (32'(rs2) << 20) | (((imm >> 5) & 32'h7F) << 25);
            default:        w = w | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                                  | (32'(rs2) << 20) | (32'(f7) << 25);
        endcase
        return w;
    endfunction

    function automatic bit refInRange(input logic [4:0] op, input logic [31:0] imm);
        longint s;
        longint u;
        s = longint'($signed(imm));
        u = longint'(imm);
        case (refFormat(op))
            F_ISGN, F_S: return (s >= -2048) && (s <= 2047);
            F_IUNS:      return u <= 4095;
            F_SH:        return u <= 63;
            F_U:         return (u % 4096) == 0;
            F_J:         return (s >= -524288) && (s <= 524287);
            default:     return 1'b1;
        endcase
    endfunction

    // ImmGen-style recovery of an S-format immediate.
    function automatic logic [31:0] immGenS(input logic [31:0] ins);
        logic [11:0] v;
        v = {ins[31:25], ins[11:7]};
        return 32'($signed(v));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit valid, input bit rdy, input bit flush,
                                 input logic [4:0] op, input logic [1:0] f2,
                                 input logic [4:0] rd, input logic [2:0] f3,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [6:0] f7, input logic [31:0] imm);
        InValid  = valid;
        OutReady = rdy;
        Flush    = flush;
        OpIn     = op;
        Funct2In = f2;
        RdIn     = rd;
        Funct3In = f3;
        Rs1In    = rs1;
        Rs2In    = rs2;
        Funct7In = f7;
        Imm32In  = imm;
    endtask

    task automatic applyRandom(input bit valid, input bit rdy, input bit flush);
        applyStimulus(valid, rdy, flush, 5'($urandom_range(0, 31)), 2'($urandom),
                      5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
                      7'($urandom), immPool[$urandom_range(0, 15)]);
    endtask

    task automatic resetModel();
        mValid = 1'b0;
        mIns   = 32'd0;
        mAddr  = 0;
        mErr   = 1'b0;
        mCnt   = 0;
    endtask

    // One clock: check InReady, advance the model with the applied inputs,
    // cross the edge and compare the registered outputs.
    task automatic tick();
        bit inRdy;
        #1;
        inRdy = !Flush && (!mValid || OutReady);
        checkOutput("InReady", 32'(InReady), 32'(inRdy));
        if (Flush) begin
            mValid = 1'b0;
            mAddr  = 0;
            mErr   = 1'b0;
        end else begin
            if (mValid && OutReady) mAddr = (mAddr + 1) % (1 << ADDR_W);
            if (InValid && inRdy) begin
                mIns   = refEncode(OpIn, Funct2In, RdIn, Funct3In, Rs1In, Rs2In, Funct7In, Imm32In);
                mErr   = CHK_ON && !refInRange(OpIn, Imm32In);
                mValid = 1'b1;
                if (mErr && mCnt < CNT_MAX) mCnt++;
            end else if (mValid && OutReady) begin
                mValid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("OutValid", 32'(OutValid), 32'(mValid));
        if (mValid) begin
            checkOutput("InsOut", InsOut, mIns);
            checkOutput("InsAddrOut", 32'(InsAddrOut), 32'(mAddr));
            checkOutput("RangeErr", 32'(RangeErr), 32'(mErr));
        end
        checkOutput("ErrCnt", 32'(ErrCnt), 32'(mCnt));
    endtask

    initial begin
        logic [31:0] holdExp;

        vecs[0]  = '{5'b00010, 2'd0, 5'd3, 3'd0, 5'd1, 5'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF08182, 1'b0};
        vecs[1]  = '{5'b10000, 2'd0, 5'd0, 3'd0, 5'd2, 5'd5, 7'd0, 32'hFFFFFFF8, 32'hFE510C10, 1'b0};
        vecs[2]  = '{5'b01110, 2'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345678, 32'h1234500E, 1'b1};
        vecs[3]  = '{5'b00000, 2'd0, 5'd1, 3'd0, 5'd2, 5'd3, 7'h20, 32'hDEADBEEF, 32'h40310080, 1'b0};
        vecs[4]  = '{5'b01011, 2'd0, 5'd6, 3'd5, 5'd4, 5'd0, 7'h20, 32'd5, 32'h4052530B, 1'b0};
        vecs[5]  = '{5'b01011, 2'd0, 5'd6, 3'd5, 5'd4, 5'd0, 7'h20, 32'd64, 32'h4002530B, 1'b1};
        vecs[6]  = '{5'b00101, 2'd3, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd4095, 32'hFFF00065, 1'b0};
        vecs[7]  = '{5'b00101, 2'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd4096, 32'h00000005, 1'b1};
        vecs[8]  = '{5'b01111, 2'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'h000007FF, 32'h7FF0000F, 1'b0};
        vecs[9]  = '{5'b01111, 2'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFF7FF, 32'h7FF0000F, 1'b1};
        vecs[10] = '{5'b01111, 2'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFF800, 32'h8000000F, 1'b0};
        vecs[11] = '{5'b10011, 2'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFF80000, 32'h80000013, 1'b0};
        vecs[12] = '{5'b10011, 2'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'h00080000, 32'h80000013, 1'b1};
        vecs[13] = '{5'b10000, 2'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'h00000800, 32'h80000010, 1'b1};

        immPool = '{32'd0, 32'd63, 32'd64, 32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF,
                    32'd4095, 32'd4096, 32'd524287, 32'd524288, 32'hFFF80000, 32'hFFF7FFFF,
                    32'h12345000, 32'h12345678, 32'hA5A5A5A5};

        // Reset and idle
        applyStimulus(0, 1, 0, 5'd0, 2'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        resetModel();
        checkOutput("rst_InsOut", InsOut, 32'd0);
        checkOutput("rst_OutValid", 32'(OutValid), 32'd0);
        checkOutput("rst_InReady", 32'(InReady), 32'd1);
        checkOutput("rst_InsAddrOut", 32'(InsAddrOut), 32'd0);
        checkOutput("rst_RangeErr", 32'(RangeErr), 32'd0);
        checkOutput("rst_ErrCnt", 32'(ErrCnt), 32'd0);
        tick();
        tick();

        // Directed vectors, back to back
        foreach (vecs[i]) begin
            applyStimulus(1, 1, 0, vecs[i].op, vecs[i].f2, vecs[i].rd, vecs[i].f3,
                          vecs[i].rs1, vecs[i].rs2, vecs[i].f7, vecs[i].imm);
            tick();
            checkOutput($sformatf("vec%0d_ins", i), InsOut, vecs[i].expIns);
            checkOutput($sformatf("vec%0d_rangeErr", i), 32'(RangeErr),
                        32'(CHK_ON ? vecs[i].expErr : 1'b0));
            if (i == 1) checkOutput("immgen_S", immGenS(InsOut), 32'hFFFFFFF8);
            if (i == 2) checkOutput("u_errcnt", 32'(ErrCnt), CHK_ON ? 32'd1 : 32'd0);
        end
        applyStimulus(0, 1, 0, 5'd0, 2'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
        tick();

        // Flush to address 0, then stall the output for 5 cycles
        applyRandom(1, 1, 1);
        tick();
        checkOutput("flush_valid", 32'(OutValid), 32'd0);
        checkOutput("flush_addr", 32'(InsAddrOut), 32'd0);
        applyStimulus(1, 0, 0, 5'b00010, 2'd1, 5'd7, 3'd2, 5'd9, 5'd0, 7'd0, 32'd100);
        holdExp = refEncode(5'b00010, 2'd1, 5'd7, 3'd2, 5'd9, 5'd0, 7'd0, 32'd100);
        tick();
        for (int k = 0; k < 5; k++) begin
            applyRandom(1, 0, 0);
            tick();
            checkOutput("stall_ins", InsOut, holdExp);
            checkOutput("stall_addr", 32'(InsAddrOut), 32'd0);
            checkOutput("stall_inready", 32'(InReady), 32'd0);
        end
        // Release: addresses continue 1,2,3 then wrap to 0
        for (int k = 0; k < 4; k++) begin
            applyRandom(1, 1, 0);
            tick();
            checkOutput("stream_addr", 32'(InsAddrOut), 32'((k + 1) % 4));
        end

        // Flush mid-stream
        applyRandom(1, 1, 1);
        tick();
        checkOutput("midflush_valid", 32'(OutValid), 32'd0);
        applyStimulus(1, 1, 0, 5'b00111, 2'd2, 5'd4, 3'd1, 5'd8, 5'd0, 7'd0, 32'd77);
        tick();
        checkOutput("postflush_addr", 32'(InsAddrOut), 32'd0);
        checkOutput("postflush_ins", InsOut,
                    refEncode(5'b00111, 2'd2, 5'd4, 3'd1, 5'd8, 5'd0, 7'd0, 32'd77));

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            applyRandom($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                        $urandom_range(0, 15) == 0);
            tick();
        end

        // Asynchronous reset while a word is held
        applyRandom(1, 0, 0);
        tick();
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("arst_valid", 32'(OutValid), 32'd0);
        checkOutput("arst_addr", 32'(InsAddrOut), 32'd0);
        checkOutput("arst_errcnt", 32'(ErrCnt), 32'd0);
        checkOutput("arst_rangeErr", 32'(RangeErr), 32'd0);
        checkOutput("arst_ins", InsOut, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        resetModel();
        applyRandom(1, 1, 0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
